// File: rtl/ovo_dag_svm_scheduler_if.sv
// Bundle of the scheduler's sample, MAC-control and winner signals between the
// scheduler (master) and the surrounding datapath/consumers (slave).
interface ovo_dag_svm_scheduler_if #(
    parameter int N_CLASSES  = 3,
    parameter int N_FEATURES = 21
) ();
    localparam int N_PAIRS = N_CLASSES * (N_CLASSES - 1) / 2;
    localparam int PAIR_W  = ($clog2(N_PAIRS) < 1) ? 1 : $clog2(N_PAIRS);
    localparam int FEAT_W  = ($clog2(N_FEATURES) < 1) ? 1 : $clog2(N_FEATURES);
    localparam int CLS_W   = ($clog2(N_CLASSES) < 1) ? 1 : $clog2(N_CLASSES);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never depends on ready, and a raised out_valid holds
    // winner stable until it is taken.
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PAIR_W-1:0] pair_idx;
    logic [FEAT_W-1:0] feat_idx;
    logic              mac_clr;
    logic              mac_en;
    logic              dec_cls;
    logic              out_valid;
    logic              out_ready;
    logic [CLS_W-1:0]  winner;
    logic              busy;
    logic [2:0]        dbg_state;

    modport master (
        input  flush, in_valid, dec_cls, out_ready,
        output in_ready, pair_idx, feat_idx, mac_clr, mac_en,
               out_valid, winner, busy, dbg_state
    );

    modport slave (
        output flush, in_valid, dec_cls, out_ready,
        input  in_ready, pair_idx, feat_idx, mac_clr, mac_en,
               out_valid, winner, busy, dbg_state
    );
endinterface

// File: rtl/ovo_dag_svm_scheduler.sv
// Decision-DAG sequencer for a shared one-vs-one SVM MAC: narrows the candidate
// range [lo,hi] by one class per pairwise classifier until a single winner remains.
module ovo_dag_svm_scheduler #(
    parameter int N_CLASSES  = 3,
    parameter int N_FEATURES = 21
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ovo_dag_svm_scheduler_if.master   bus
);
    localparam int N_PAIRS = N_CLASSES * (N_CLASSES - 1) / 2;
    localparam int PAIR_W  = ($clog2(N_PAIRS) < 1) ? 1 : $clog2(N_PAIRS);
    localparam int FEAT_W  = ($clog2(N_FEATURES) < 1) ? 1 : $clog2(N_FEATURES);
    localparam int CLS_W   = ($clog2(N_CLASSES) < 1) ? 1 : $clog2(N_CLASSES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_ACCUM  = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [FEAT_W-1:0] FEAT_LAST = FEAT_W'(N_FEATURES - 1);
    localparam logic [CLS_W-1:0]  CLS_LAST  = CLS_W'(N_CLASSES - 1);

    logic [2:0]        state;
    logic [CLS_W-1:0]  lo;
    logic [CLS_W-1:0]  hi;
    logic [CLS_W-1:0]  lo_dec;
    logic [CLS_W-1:0]  hi_dec;
    logic [CLS_W-1:0]  winner_q;
    logic [FEAT_W-1:0] feat_q;
    int                pair_calc;

    // Candidate range after applying this cycle's pairwise decision.
    always_comb begin
        lo_dec = lo;
        hi_dec = hi;
        if (bus.dec_cls) lo_dec = lo + CLS_W'(1);
        else             hi_dec = hi - CLS_W'(1);
    end

    // Lexicographic index of classifier (lo,hi); forced to 0 while idle so the
    // reset value holds and a stale range from the last sample is never shown.
    always_comb begin
        pair_calc = (int'(lo) * (2 * N_CLASSES - int'(lo) - 1)) / 2
                  + (int'(hi) - int'(lo) - 1);
        bus.pair_idx = (state == S_IDLE) ? '0 : PAIR_W'(pair_calc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lo       <= '0;
            hi       <= CLS_LAST;
            feat_q   <= '0;
            winner_q <= '0;
        end else if (bus.flush) begin
            state  <= S_IDLE;
            feat_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        lo    <= '0;
                        hi    <= CLS_LAST;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    feat_q <= '0;
                    state  <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (feat_q == FEAT_LAST) begin
                        feat_q <= '0;
                        state  <= S_DECIDE;
                    end else begin
                        feat_q <= feat_q + FEAT_W'(1);
                    end
                end
                S_DECIDE: begin
                    // The final pair is left in lo/hi so pair_idx stays meaningful in DONE.
                    if (lo_dec == hi_dec) begin
                        winner_q <= lo_dec;
                        state    <= S_DONE;
                    end else begin
                        lo    <= lo_dec;
                        hi    <= hi_dec;
                        state <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.mac_clr   = (state == S_CLEAR);
    assign bus.mac_en    = (state == S_ACCUM);
    assign bus.out_valid = (state == S_DONE);
    assign bus.feat_idx  = feat_q;
    assign bus.winner    = winner_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_ovo_dag_svm_scheduler.sv
// Scoreboard bench for two scheduler configurations (3 classes x 21 features,
// 4 classes x 3 features) with directed decision sequences.
module tb_ovo_dag_svm_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic rst_n[2];
    logic in_valid[2];
    logic flush[2];
    logic dec_cls[2];
    logic out_ready[2];

    logic [7:0] o_state[2];
    logic [7:0] o_pair[2];
    logic [7:0] o_feat[2];
    logic [7:0] o_win[2];
    logic       o_in_ready[2];
    logic       o_clr[2];
    logic       o_en[2];
    logic       o_ov[2];
    logic       o_busy[2];

    // {dut, winner, expected out_valid cycle}
    logic [31:0] exp_q[$];
    // {dut, pair_idx}
    logic [7:0]  exp_pair_q[$];
    // {dut, decision}
    logic [7:0]  dec_q[$];

    ovo_dag_svm_scheduler_if #(.N_CLASSES(3), .N_FEATURES(21)) bus_a ();
    ovo_dag_svm_scheduler_if #(.N_CLASSES(4), .N_FEATURES(3))  bus_b ();

    ovo_dag_svm_scheduler #(.N_CLASSES(3), .N_FEATURES(21)) u_a (
        .clk   (clk),
        .rst_n (rst_n[0]),
        .bus   (bus_a)
    );

    ovo_dag_svm_scheduler #(.N_CLASSES(4), .N_FEATURES(3)) u_b (
        .clk   (clk),
        .rst_n (rst_n[1]),
        .bus   (bus_b)
    );

    assign bus_a.in_valid  = in_valid[0];
    assign bus_a.flush     = flush[0];
    assign bus_a.dec_cls   = dec_cls[0];
    assign bus_a.out_ready = out_ready[0];
    assign bus_b.in_valid  = in_valid[1];
    assign bus_b.flush     = flush[1];
    assign bus_b.dec_cls   = dec_cls[1];
    assign bus_b.out_ready = out_ready[1];

    assign o_state[0]    = 8'(bus_a.dbg_state);
    assign o_pair[0]     = 8'(bus_a.pair_idx);
    assign o_feat[0]     = 8'(bus_a.feat_idx);
    assign o_win[0]      = 8'(bus_a.winner);
    assign o_in_ready[0] = bus_a.in_ready;
    assign o_clr[0]      = bus_a.mac_clr;
    assign o_en[0]       = bus_a.mac_en;
    assign o_ov[0]       = bus_a.out_valid;
    assign o_busy[0]     = bus_a.busy;
    assign o_state[1]    = 8'(bus_b.dbg_state);
    assign o_pair[1]     = 8'(bus_b.pair_idx);
    assign o_feat[1]     = 8'(bus_b.feat_idx);
    assign o_win[1]      = 8'(bus_b.winner);
    assign o_in_ready[1] = bus_b.in_ready;
    assign o_clr[1]      = bus_b.mac_clr;
    assign o_en[1]       = bus_b.mac_en;
    assign o_ov[1]       = bus_b.out_valid;
    assign o_busy[1]     = bus_b.busy;

    function automatic int nf(input int d);
        return (d == 0) ? 21 : 3;
    endfunction

    function automatic int ncls(input int d);
        return (d == 0) ? 3 : 4;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Pairwise-decision model: answers from dec_q in DECIDE, noise elsewhere.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n[d] && o_state[d] == 8'd3) begin
                    if (dec_q.size() == 0) begin
                        check("dec_underflow", 1, 0);
                    end else begin
                        e = dec_q.pop_front();
                        check("dec_dut", int'(e[7:4]), d);
                        dec_cls[d] = e[0];
                    end
                end else begin
                    dec_cls[d] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Monitor: MAC strobe sequencing, pair order, winner and latency.
    initial begin
        int         clr_cnt[2];
        int         en_run[2];
        int         en_tot[2];
        logic [7:0] cur_pair[2];
        logic       prev_ov[2];
        logic [31:0] ew;
        logic [7:0]  ep;
        for (int d = 0; d < 2; d++) begin
            clr_cnt[d] = 0; en_run[d] = 0; en_tot[d] = 0;
            cur_pair[d] = '0; prev_ov[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n[d] || o_state[d] == 8'd0) begin
                    clr_cnt[d] = 0;
                    en_tot[d]  = 0;
                end
                if (rst_n[d]) begin
                    if (o_clr[d]) begin
                        clr_cnt[d]++;
                        if (exp_pair_q.size() == 0) begin
                            check("pair_unexpected", 1, 0);
                        end else begin
                            ep = exp_pair_q.pop_front();
                            check("pair_dut", int'(ep[7:4]), d);
                            check("pair_idx", int'(o_pair[d]), int'(ep[3:0]));
                            cur_pair[d] = o_pair[d];
                        end
                    end
                    if (o_en[d]) begin
                        check("feat_idx", int'(o_feat[d]), en_run[d]);
                        check("pair_stable", int'(o_pair[d]), int'(cur_pair[d]));
                        en_run[d]++;
                        en_tot[d]++;
                    end else begin
                        if (o_state[d] == 8'd3) check("mac_en_run", en_run[d], nf(d));
                        en_run[d] = 0;
                    end
                    if (o_ov[d] && !prev_ov[d]) begin
                        if (exp_q.size() == 0) begin
                            check("out_unexpected", 1, 0);
                        end else begin
                            ew = exp_q.pop_front();
                            check("out_dut", int'(ew[31:28]), d);
                            check("winner", int'(o_win[d]), int'(ew[27:24]));
                            check("latency_cycle", cyc, int'(ew[23:0]));
                            check("clr_pulses", clr_cnt[d], ncls(d) - 1);
                            check("en_cycles", en_tot[d], (ncls(d) - 1) * nf(d));
                        end
                    end
                end
                prev_ov[d] = rst_n[d] ? o_ov[d] : 1'b0;
            end
        end
    end

    task automatic push_plan(input int d, input logic [3:0] decs, input int n,
                             input logic [11:0] pairs);
        for (int i = 0; i < n; i++) begin
            exp_pair_q.push_back({4'(d), pairs[i*4 +: 4]});
            dec_q.push_back({4'(d), 3'b000, decs[i]});
        end
    endtask

    task automatic accept(input int d);
        @(negedge clk);
        check("in_ready_idle", int'(o_in_ready[d]), 1);
        in_valid[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        check("busy_after_accept", int'(o_busy[d]), 1);
    endtask

    task automatic run_sample(input int d, input logic [3:0] decs, input int n,
                              input logic [11:0] pairs, input int win, input int hold);
        int waited;
        push_plan(d, decs, n, pairs);
        accept(d);
        exp_q.push_back({4'(d), 4'(win), 24'(cyc + (ncls(d) - 1) * (nf(d) + 2))});
        waited = 0;
        while (!o_ov[d] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("out_valid_arrives", int'(o_ov[d]), 1);
        for (int i = 0; i < hold; i++) begin
            in_valid[d] = (i % 2 == 0);
            @(negedge clk);
            check("hold_out_valid", int'(o_ov[d]), 1);
            check("hold_winner", int'(o_win[d]), win);
            check("hold_in_ready", int'(o_in_ready[d]), 0);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check("post_take_out_valid", int'(o_ov[d]), 0);
        check("post_take_in_ready", int'(o_in_ready[d]), 1);
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_state"}, int'(o_state[d]), 0);
        check({tag, "_in_ready"}, int'(o_in_ready[d]), 1);
        check({tag, "_busy"}, int'(o_busy[d]), 0);
        check({tag, "_mac_clr"}, int'(o_clr[d]), 0);
        check({tag, "_mac_en"}, int'(o_en[d]), 0);
        check({tag, "_out_valid"}, int'(o_ov[d]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; in_valid[d] = 1'b0; flush[d] = 1'b0;
            dec_cls[d] = 1'b0; out_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset values
        for (int d = 0; d < 2; d++) begin
            check_idle(d, "reset");
            check("reset_pair_idx", int'(o_pair[d]), 0);
            check("reset_feat_idx", int'(o_feat[d]), 0);
            check("reset_winner", int'(o_win[d]), 0);
        end
        check("reset_lo", int'(u_a.lo), 0);
        check("reset_hi", int'(u_a.hi), 2);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // Four decision paths through the 3-class DAG
        run_sample(0, 4'b0000, 2, 12'h001, 0, 0);
        run_sample(0, 4'b0001, 2, 12'h021, 1, 0);
        run_sample(0, 4'b0011, 2, 12'h021, 2, 0);
        run_sample(0, 4'b0010, 2, 12'h001, 1, 0);

        // Consumer stall with in_valid pulses while the winner is held
        run_sample(0, 4'b0011, 2, 12'h021, 2, 5);

        // Asynchronous reset in the middle of the first classifier
        exp_pair_q.push_back({4'd0, 4'd1});
        accept(0);
        waited = 0;
        while (!(o_en[0] && o_feat[0] == 8'd10) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("reached_feat10", int'(o_feat[0]), 10);
        rst_n[0] = 1'b0;
        #1;
        check_idle(0, "midreset");
        check("midreset_feat_idx", int'(o_feat[0]), 0);
        check("midreset_pair_idx", int'(o_pair[0]), 0);
        check("midreset_winner", int'(o_win[0]), 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        run_sample(0, 4'b0000, 2, 12'h001, 0, 0);

        // Flush in DECIDE with dec_cls=1: nothing committed
        exp_pair_q.push_back({4'd0, 4'd1});
        dec_q.push_back({4'd0, 4'd1});
        accept(0);
        waited = 0;
        while (o_state[0] != 8'd3 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("reached_decide", int'(o_state[0]), 3);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        check_idle(0, "flush_decide");
        check("flush_lo_kept", int'(u_a.lo), 0);
        check("flush_hi_kept", int'(u_a.hi), 2);

        // Flush beats acceptance in IDLE
        in_valid[0] = 1'b1;
        flush[0]    = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        flush[0]    = 1'b0;
        check_idle(0, "flush_idle");
        @(negedge clk);
        check_idle(0, "flush_idle_after");

        run_sample(0, 4'b0001, 2, 12'h021, 1, 0);

        // 4-class DAG: (0,3)->(0,2)->(1,2), winner 2 after 15 cycles
        run_sample(1, 4'b0110, 3, 12'h312, 2, 0);
        run_sample(1, 4'b0000, 3, 12'h012, 0, 2);

        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("pair_q_drained", exp_pair_q.size(), 0);
        check("dec_q_drained", dec_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
